// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle between the ALU issue stage (slave) and its surroundings (master):
// instruction source, register file and ALU. ILLEGAL_TRAP_EN adds the illegal trap output.
interface alu_issue_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int DATA_W = 16
);
  logic [15:0]       instr;
  logic              instr_vld;
  logic              instr_rdy;
  logic [REG_AW-1:0] rf_ra_a;
  logic [REG_AW-1:0] rf_ra_b;
  logic [DATA_W-1:0] rf_rd_a;
  logic [DATA_W-1:0] rf_rd_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [3:0]        alu_ext;
  logic              alu_cin;
  logic [DATA_W-1:0] alu_s;
  logic [4:0]        alu_flags;
  logic              rf_we;
  logic [REG_AW-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic [4:0]        psr;
  logic              done;

`ifdef ILLEGAL_TRAP_EN
  logic              illegal;

  modport master (
    output instr, instr_vld, rf_rd_a, rf_rd_b, alu_s, alu_flags,
    input  instr_rdy, rf_ra_a, rf_ra_b, alu_a, alu_b, alu_op, alu_ext, alu_cin,
           rf_we, rf_wa, rf_wd, psr, done, illegal
  );

  modport slave (
    input  instr, instr_vld, rf_rd_a, rf_rd_b, alu_s, alu_flags,
    output instr_rdy, rf_ra_a, rf_ra_b, alu_a, alu_b, alu_op, alu_ext, alu_cin,
           rf_we, rf_wa, rf_wd, psr, done, illegal
  );
`else
  modport master (
    output instr, instr_vld, rf_rd_a, rf_rd_b, alu_s, alu_flags,
    input  instr_rdy, rf_ra_a, rf_ra_b, alu_a, alu_b, alu_op, alu_ext, alu_cin,
           rf_we, rf_wa, rf_wd, psr, done
  );

  modport slave (
    input  instr, instr_vld, rf_rd_a, rf_rd_b, alu_s, alu_flags,
    output instr_rdy, rf_ra_a, rf_ra_b, alu_a, alu_b, alu_op, alu_ext, alu_cin,
           rf_we, rf_wa, rf_wd, psr, done
  );
`endif

endinterface

// File: rtl/alu_issue_ctrl.sv
// Decode/issue stage for the 16-bit ALU: IDLE -> EXEC -> WB, one instruction per 3 cycles.
// Define ILLEGAL_TRAP_EN to trap undefined {opcode,opext} encodings instead of writing them back.
module alu_issue_ctrl #(
  parameter int         REG_AW  = 4,
  parameter int         DATA_W  = 16,
  parameter logic [4:0] PSR_RST = 5'b0
) (
  input  logic           clk,
  input  logic           rst,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_REGU  = 4'b1010;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_CMPU = 4'b0010;
  localparam logic [3:0] EXT_NOP  = 4'b0000;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       ir;
  logic [REG_AW-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic [4:0]        flags_pend;
  logic [4:0]        psr_q;

  logic [3:0]        ir_op;
  logic [3:0]        ir_ext;
  logic [7:0]        ir_imm;
  logic              reg_form;
  logic              sext_form;
  logic              is_nop;
  logic              is_cmp;
  logic              wb_write;
  logic              wb_psr;
  logic              accept;
  logic [DATA_W-1:0] b_opnd;

  logic              rdy;
  logic              we;
  logic              done_p;
  logic [REG_AW-1:0] ra_a;
  logic [REG_AW-1:0] ra_b;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [3:0]        op_out;
  logic [3:0]        ext_out;

  assign ir_op  = ir[15:12];
  assign ir_ext = ir[7:4];
  assign ir_imm = ir[7:0];

  // Register forms read B from Rsrc; everything else takes the 8-bit immediate.
  assign reg_form  = (ir_op == OP_REG) || (ir_op == OP_REGU);
  assign sext_form = (ir_op == OP_ADDI) || (ir_op == OP_ADDCI) ||
                     (ir_op == OP_SUBI) || (ir_op == OP_CMPI);

  always_comb begin
    if (reg_form)
      b_opnd = bus.rf_rd_b;
    else if (sext_form)
      b_opnd = {{(DATA_W-8){ir_imm[7]}}, ir_imm};
    else
      b_opnd = {{(DATA_W-8){1'b0}}, ir_imm};
  end

  assign is_nop = (ir_op == OP_REG) && (ir_ext == EXT_NOP);
  assign is_cmp = ((ir_op == OP_REG)  && (ir_ext == EXT_CMP))  ||
                  (ir_op == OP_CMPI)                           ||
                  ((ir_op == OP_REGU) && (ir_ext == EXT_CMPU));

`ifdef ILLEGAL_TRAP_EN
  // Encodings the ALU implements; NOP is handled separately and never traps.
  function automatic logic is_legal(input logic [3:0] op, input logic [3:0] ext);
    case (op)
      4'b0000: is_legal = (ext == 4'b0001) || (ext == 4'b0010) || (ext == 4'b0011) ||
                          (ext == 4'b0100) || (ext == 4'b0101) || (ext == 4'b0110) ||
                          (ext == 4'b0111) || (ext == 4'b1001) || (ext == 4'b1011) ||
                          (ext == 4'b1101);
      4'b1010: is_legal = (ext == EXT_CMPU);
      4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
      4'b0111, 4'b1001, 4'b1011, 4'b1101:
               is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  logic is_illegal;
  assign is_illegal = !is_nop && !is_legal(ir_op, ir_ext);
  assign wb_write   = !is_nop && !is_cmp && !is_illegal;
  assign wb_psr     = !is_nop && !is_illegal;
  assign bus.illegal = (state == WB) && is_illegal;
`else
  assign wb_write = !is_nop && !is_cmp;
  assign wb_psr   = !is_nop;
`endif

  assign accept = (state == IDLE) && bus.instr_vld;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    we        = 1'b0;
    done_p    = 1'b0;
    ra_a      = '0;
    ra_b      = '0;
    opnd_a    = '0;
    opnd_b    = '0;
    op_out    = '0;
    ext_out   = '0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bus.instr_vld) state_nxt = EXEC;
      end
      EXEC: begin
        ra_a      = ir[11:8];
        ra_b      = ir[3:0];
        opnd_a    = bus.rf_rd_a;
        opnd_b    = b_opnd;
        op_out    = ir_op;
        ext_out   = ir_ext;
        state_nxt = WB;
      end
      WB: begin
        we        = wb_write;
        done_p    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  // The instruction and result registers are plain flops, so they are reset
  // along with the FSM to keep all outputs at zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ir         <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
      flags_pend <= '0;
      psr_q      <= PSR_RST;
    end else begin
      state <= state_nxt;
      if (accept) ir <= bus.instr;
      if (state == EXEC) begin
        wd_q       <= bus.alu_s;
        wa_q       <= ir[11:8];
        flags_pend <= bus.alu_flags;
      end
      // Flags land at the end of WB, in time for the next instruction's EXEC.
      if ((state == WB) && wb_psr) psr_q <= flags_pend;
    end
  end

  assign bus.instr_rdy = rdy;
  assign bus.rf_ra_a   = ra_a;
  assign bus.rf_ra_b   = ra_b;
  assign bus.alu_a     = opnd_a;
  assign bus.alu_b     = opnd_b;
  assign bus.alu_op    = op_out;
  assign bus.alu_ext   = ext_out;
  assign bus.alu_cin   = psr_q[4];
  assign bus.rf_we     = we;
  assign bus.rf_wa     = wa_q;
  assign bus.rf_wd     = wd_q;
  assign bus.psr       = psr_q;
  assign bus.done      = done_p;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: behavioural register file and ALU around the stage,
// hand-computed expectations per scenario.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Register file: asynchronous read, write on rf_we or on a bench preset.
  logic [15:0] rf [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_a  = '0;
  logic [15:0] pre_d  = '0;

  always @(posedge clk) begin
    if (bus.rf_we)   rf[bus.rf_wa] <= bus.rf_wd;
    else if (pre_we) rf[pre_a]     <= pre_d;
  end

  assign bus.rf_rd_a = rf[bus.rf_ra_a];
  assign bus.rf_rd_b = rf[bus.rf_ra_b];

  // Reference ALU returning {C,L,F,Z,N, S}.
  function automatic logic [20:0] alu_model(input logic [3:0] op, input logic [3:0] ext,
                                            input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
    logic [16:0] sum;
    logic [15:0] s;
    logic [4:0]  fl;
    logic [3:0]  f;
    sum = '0;
    s   = '0;
    fl  = '0;
    if (op == 4'b0000)                         f = ext;
    else if (op == 4'b1010 && ext == 4'b0010) f = 4'b1110;
    else                                       f = op;
    case (f)
      4'b0101, 4'b0110, 4'b0111: begin
        sum   = {1'b0, a} + {1'b0, b} + ((f == 4'b0111) ? {16'b0, cin} : 17'b0);
        s     = sum[15:0];
        fl[4] = sum[16];
        if (f != 4'b0110) fl[2] = (a[15] == b[15]) && (s[15] != a[15]);
      end
      4'b1011: begin
        fl[3] = a < b;
        fl[1] = a == b;
        fl[0] = $signed(a) < $signed(b);
      end
      4'b1110: begin
        fl[3] = a < b;
        fl[1] = a == b;
      end
      4'b0001: s = a & b;
      4'b0010: s = a | b;
      4'b0011: s = a ^ b;
      4'b1001: s = a - b;
      4'b1101: s = b;
      default: ;
    endcase
    return {fl, s};
  endfunction

  assign {bus.alu_flags, bus.alu_s} = alu_model(bus.alu_op, bus.alu_ext, bus.alu_a,
                                                bus.alu_b, bus.alu_cin);

  // Values observed in the EXEC and WB cycles of the last issued instruction.
  logic [15:0] ex_a, ex_b;
  logic [3:0]  ex_op, ex_ext, ex_ra_a, ex_ra_b;
  logic        ex_cin, ex_rdy, ex_done, ex_we;
  logic        wb_we, wb_done, wb_rdy;
  logic [3:0]  wb_wa;
  logic [15:0] wb_wd;

  task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one instruction and record EXEC/WB observations; returns one cycle after WB.
  task automatic issue(input logic [15:0] ins);
    int k;
    @(negedge clk);
    k = 0;
    while (!bus.instr_rdy && k < 8) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (bus.instr_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL issue_rdy_timeout: instr_rdy=%b required 1", bus.instr_rdy);
    end
    bus.instr     = ins;
    bus.instr_vld = 1'b1;
    @(negedge clk);
    bus.instr_vld = 1'b0;
    bus.instr     = '0;
    #1;
    ex_a = bus.alu_a;     ex_b = bus.alu_b;     ex_op = bus.alu_op;  ex_ext = bus.alu_ext;
    ex_ra_a = bus.rf_ra_a; ex_ra_b = bus.rf_ra_b; ex_cin = bus.alu_cin;
    ex_rdy = bus.instr_rdy; ex_done = bus.done;  ex_we = bus.rf_we;
    @(negedge clk);
    #1;
    wb_we = bus.rf_we; wb_done = bus.done; wb_rdy = bus.instr_rdy;
    wb_wa = bus.rf_wa; wb_wd = bus.rf_wd;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (bus.instr_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy: got %b want 1", bus.instr_rdy); end
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", bus.rf_we); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_vec++; if (bus.psr !== 5'b00000) begin n_err++; $display("FAIL rst_psr: got %b want 00000", bus.psr); end
    n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_ext, bus.alu_cin} !== 41'd0) begin
      n_err++; $display("FAIL rst_alu: a=%h b=%h op=%h ext=%h cin=%b want all 0",
                        bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_ext, bus.alu_cin); end
    n_vec++; if ({bus.rf_ra_a, bus.rf_ra_b, bus.rf_wa, bus.rf_wd} !== 28'd0) begin
      n_err++; $display("FAIL rst_rf: ra_a=%h ra_b=%h wa=%h wd=%h want all 0",
                        bus.rf_ra_a, bus.rf_ra_b, bus.rf_wa, bus.rf_wd); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    set_reg(4'd1, 16'h7FFF);
    set_reg(4'd2, 16'h0001);
    issue(16'h0152);
    n_vec++; if ({ex_op, ex_ext} !== 8'h05) begin n_err++; $display("FAIL add_opext: got %h want 05", {ex_op, ex_ext}); end
    n_vec++; if ({ex_ra_a, ex_ra_b} !== 8'h12) begin n_err++; $display("FAIL add_ra: got %h want 12", {ex_ra_a, ex_ra_b}); end
    n_vec++; if ({ex_a, ex_b} !== 32'h7FFF_0001) begin n_err++; $display("FAIL add_ab: got %h want 7fff0001", {ex_a, ex_b}); end
    n_vec++; if ({ex_rdy, ex_done, ex_we} !== 3'b000) begin n_err++; $display("FAIL add_exec_ctl: got %b want 000", {ex_rdy, ex_done, ex_we}); end
    n_vec++; if ({wb_we, wb_done, wb_rdy} !== 3'b110) begin n_err++; $display("FAIL add_wb_ctl: got %b want 110", {wb_we, wb_done, wb_rdy}); end
    n_vec++; if ({wb_wa, wb_wd} !== 20'h1_8000) begin n_err++; $display("FAIL add_wb: got %h want 18000", {wb_wa, wb_wd}); end
    n_vec++; if (rf[1] !== 16'h8000) begin n_err++; $display("FAIL add_r1: got %h want 8000", rf[1]); end
    n_vec++; if (bus.psr !== 5'b00100) begin n_err++; $display("FAIL add_psr: got %b want 00100", bus.psr); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_cmp();
    set_reg(4'd3, 16'h0004);
    set_reg(4'd4, 16'h0004);
    issue(16'h03B4);
    n_vec++; if ({wb_we, wb_done} !== 2'b01) begin n_err++; $display("FAIL cmp_wb_ctl: got %b want 01", {wb_we, wb_done}); end
    n_vec++; if (bus.psr !== 5'b00010) begin n_err++; $display("FAIL cmp_psr: got %b want 00010", bus.psr); end
    // CMPU is a register form under opcode 1010: B must come from Rsrc.
    set_reg(4'd3, 16'h0001);
    set_reg(4'd4, 16'h0002);
    issue(16'hA324);
    n_vec++; if ({ex_a, ex_b} !== 32'h0001_0002) begin n_err++; $display("FAIL cmpu_ab: got %h want 00010002", {ex_a, ex_b}); end
    n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL cmpu_we: got %b want 0", wb_we); end
    n_vec++; if (bus.psr !== 5'b01000) begin n_err++; $display("FAIL cmpu_psr: got %b want 01000", bus.psr); end
  endtask

  task automatic test_zero_ext();
    set_reg(4'd2, 16'h0001);
    issue(16'h62FF);
    n_vec++; if (ex_b !== 16'h00FF) begin n_err++; $display("FAIL addui_b: got %h want 00ff", ex_b); end
    n_vec++; if (rf[2] !== 16'h0100) begin n_err++; $display("FAIL addui_r2: got %h want 0100", rf[2]); end
    n_vec++; if (bus.psr !== 5'b00000) begin n_err++; $display("FAIL addui_psr: got %b want 00000", bus.psr); end
  endtask

  task automatic test_addi_sext();
    set_reg(4'd1, 16'h0005);
    issue(16'h51FF);
    n_vec++; if ({ex_a, ex_b} !== 32'h0005_FFFF) begin n_err++; $display("FAIL addi_ab: got %h want 0005ffff", {ex_a, ex_b}); end
    n_vec++; if (rf[1] !== 16'h0004) begin n_err++; $display("FAIL addi_r1: got %h want 0004", rf[1]); end
    n_vec++; if (bus.psr !== 5'b10000) begin n_err++; $display("FAIL addi_psr: got %b want 10000", bus.psr); end
  endtask

  task automatic test_carry_chain();
    set_reg(4'd1, 16'h0001);
    set_reg(4'd2, 16'h0001);
    n_vec++; if (bus.alu_cin !== 1'b1) begin n_err++; $display("FAIL cin_idle: got %b want 1", bus.alu_cin); end
    issue(16'h0172);
    n_vec++; if (ex_cin !== 1'b1) begin n_err++; $display("FAIL addc_cin: got %b want 1", ex_cin); end
    n_vec++; if (rf[1] !== 16'h0003) begin n_err++; $display("FAIL addc_r1: got %h want 0003", rf[1]); end
    n_vec++; if (bus.psr !== 5'b00000) begin n_err++; $display("FAIL addc_psr: got %b want 00000", bus.psr); end
  endtask

  task automatic test_same_addr_nop();
    set_reg(4'd3, 16'h1234);
    issue(16'h03B3);
    n_vec++; if ({ex_a, ex_b} !== 32'h1234_1234) begin n_err++; $display("FAIL same_ab: got %h want 12341234", {ex_a, ex_b}); end
    n_vec++; if (bus.psr !== 5'b00010) begin n_err++; $display("FAIL same_psr: got %b want 00010", bus.psr); end
    issue(16'h0000);
    n_vec++; if ({wb_we, wb_done} !== 2'b01) begin n_err++; $display("FAIL nop_wb_ctl: got %b want 01", {wb_we, wb_done}); end
    n_vec++; if (bus.psr !== 5'b00010) begin n_err++; $display("FAIL nop_psr: got %b want 00010", bus.psr); end
  endtask

  task automatic test_back_to_back();
    int accepts, dones, rdy_low;
    accepts = 0; dones = 0; rdy_low = 0;
    @(negedge clk);
    bus.instr     = 16'h0152;
    bus.instr_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bus.instr_vld && bus.instr_rdy) accepts++;
      if (!bus.instr_rdy) rdy_low++;
      if (bus.done) dones++;
    end
    bus.instr_vld = 1'b0;
    n_vec++; if (accepts !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", accepts); end
    n_vec++; if (dones !== 2) begin n_err++; $display("FAIL b2b_done: got %0d want 2", dones); end
    n_vec++; if (rdy_low !== 4) begin n_err++; $display("FAIL b2b_rdy_low: got %0d want 4", rdy_low); end
  endtask

  task automatic test_async_reset();
    logic we_seen;
    set_reg(4'd1, 16'h0005);
    issue(16'h51FF);
    n_vec++; if (bus.psr !== 5'b10000) begin n_err++; $display("FAIL arst_pre_psr: got %b want 10000", bus.psr); end
    set_reg(4'd2, 16'h0001);
    @(negedge clk);
    bus.instr     = 16'h0152;
    bus.instr_vld = 1'b1;
    @(negedge clk);
    bus.instr_vld = 1'b0;
    #1;
    n_vec++; if (bus.instr_rdy !== 1'b0) begin n_err++; $display("FAIL arst_in_exec: rdy=%b want 0", bus.instr_rdy); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if ({bus.psr, bus.instr_rdy, bus.rf_we} !== 7'b00000_1_0) begin
      n_err++; $display("FAIL arst_now: psr=%b rdy=%b we=%b want 00000 1 0", bus.psr, bus.instr_rdy, bus.rf_we); end
    we_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (bus.rf_we) we_seen = 1'b1;
      if (i == 0) rst = 1'b0;
    end
    n_vec++; if (we_seen !== 1'b0) begin n_err++; $display("FAIL arst_we: got %b want 0", we_seen); end
    n_vec++; if (rf[1] !== 16'h0004) begin n_err++; $display("FAIL arst_r1: got %h want 0004", rf[1]); end
    n_vec++; if ({bus.psr, bus.instr_rdy} !== 6'b00000_1) begin
      n_err++; $display("FAIL arst_after: psr=%b rdy=%b want 00000 1", bus.psr, bus.instr_rdy); end
  endtask

  initial begin
    bus.instr     = '0;
    bus.instr_vld = 1'b0;
    test_reset();
    test_add_overflow();
    test_cmp();
    test_zero_ext();
    test_addi_sext();
    test_carry_chain();
    test_same_addr_nop();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
